// File: rtl/core_dbg_pkg.sv
// Shared types and constants for the core debug unit: command codes,
// controller states, halt causes and status-word bit positions.
package core_dbg_pkg;

    typedef enum logic [7:0] {
        CMD_NONE   = 8'h00,
        CMD_HALT   = 8'h01,
        CMD_RESUME = 8'h02,
        CMD_RD_REG = 8'h03,
        CMD_WR_REG = 8'h04,
        CMD_RD_PC  = 8'h05,
        CMD_WR_PC  = 8'h06,
        CMD_STEP   = 8'h07,
        CMD_SET_BP = 8'h08,
        CMD_CLR_BP = 8'h09,
        CMD_STATUS = 8'h0A
    } dbg_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HALT,
        ST_EXEC,
        ST_STEP_RUN,
        ST_STEP_STOP,
        ST_DONE,
        ST_WAIT_CLR
    } dbg_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_DBG  = 2'd1,
        CAUSE_BP   = 2'd2,
        CAUSE_STEP = 2'd3
    } halt_cause_e;

    localparam int STAT_HALT_BIT   = 0;
    localparam int STAT_HALTED_BIT = 1;
    localparam int STAT_CAUSE_LSB  = 2;
    localparam int STAT_BPIDX_LSB  = 4;
    localparam int STAT_ERR_BIT    = 8;
    localparam int STAT_BPEN_LSB   = 16;

    // Commands that touch core state and therefore need a drained pipeline.
    function automatic logic needs_halted(input logic [7:0] cmd);
        return (cmd == CMD_RD_REG) || (cmd == CMD_WR_REG) || (cmd == CMD_WR_PC);
    endfunction

endpackage

// File: rtl/core_dbg_bp_unit.sv
// Hardware PC breakpoint bank: per-entry address/enable registers with a
// set/clear port and a lowest-index-wins match encoder.
module core_dbg_bp_unit
    import core_dbg_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 4
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              set,
    input  logic              clr,
    input  logic [3:0]        sel,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   pc,
    input  logic              check,
    output logic              hit,
    output logic [3:0]        idx,
    output logic [NUM_BP-1:0] en
);

    logic [XLEN-1:0]   bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_en_q;
    logic [NUM_BP-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
            always_ff @(posedge clk or negedge rstn_i) begin
                if (!rstn_i) begin
                    bp_addr_q[gi] <= '0;
                    bp_en_q[gi]   <= 1'b0;
                end else if (set && (sel == 4'(gi))) begin
                    bp_addr_q[gi] <= addr;
                    bp_en_q[gi]   <= 1'b1;
                end else if (clr && (sel == 4'(gi))) begin
                    bp_addr_q[gi] <= '0;
                    bp_en_q[gi]   <= 1'b0;
                end
            end

            assign match[gi] = bp_en_q[gi] && (pc == bp_addr_q[gi]);
        end
    endgenerate

    // Scan downwards so the lowest matching entry is the one that sticks.
    always_comb begin
        idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign hit = check && (|match);
    assign en  = bp_en_q;

endmodule

// File: rtl/core_dbg_unit.sv
// Debug controller between a debug bus master and one core: halt/resume,
// register and PC access, single-step and PC breakpoints.
module core_dbg_unit
    import core_dbg_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RF_AW        = 5,
    parameter int NUM_BP       = 4,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic [7:0]       dbg_cmd_i,
    input  logic [XLEN-1:0]  dbg_addr_i,
    input  logic [XLEN-1:0]  dbg_wdata_i,
    output logic [XLEN-1:0]  dbg_rdata_o,
    output logic             dbg_done_o,
    output logic             halt_o,
    input  logic             halted_i,
    input  logic             retire_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic [RF_AW-1:0] rs_o,
    input  logic [XLEN-1:0]  rs_data_i,
    output logic [RF_AW-1:0] rd_o,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             rd_we_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             flush_o
);

    dbg_state_e        state_q, state_next;
    logic [7:0]        cmd_q;
    logic              halt_q;
    logic              tmp_q;
    logic              step_hold_q;
    logic              suppress_q;
    logic              err_q;
    halt_cause_e       cause_q;
    logic [3:0]        bp_idx_q;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   status_word;

    logic              accept;
    logic [7:0]        eff_cmd;
    logic              bp_sel_ok;
    logic              bp_set;
    logic              bp_clr;
    logic              bp_check;
    logic              bp_hit;
    logic [3:0]        bp_idx;
    logic [NUM_BP-1:0] bp_en;

    // A step request on a running core degenerates into a plain halt.
    assign eff_cmd   = ((dbg_cmd_i == CMD_STEP) && !halt_q) ? 8'(CMD_HALT) : dbg_cmd_i;
    assign accept    = (state_q == ST_IDLE) && (dbg_cmd_i != 8'(CMD_NONE));
    assign bp_sel_ok = dbg_addr_i < XLEN'(NUM_BP);
    assign bp_set    = accept && (eff_cmd == CMD_SET_BP) && bp_sel_ok;
    assign bp_clr    = accept && (eff_cmd == CMD_CLR_BP) && bp_sel_ok;
    assign bp_check  = !halted_i && !halt_q && !suppress_q;

    core_dbg_bp_unit #(
        .XLEN   (XLEN),
        .NUM_BP (NUM_BP)
    ) u_bp (
        .clk    (clk),
        .rstn_i (rstn_i),
        .set    (bp_set),
        .clr    (bp_clr),
        .sel    (dbg_addr_i[3:0]),
        .addr   (dbg_wdata_i),
        .pc     (pc_i),
        .check  (bp_check),
        .hit    (bp_hit),
        .idx    (bp_idx),
        .en     (bp_en)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg_cmd_i != 8'(CMD_NONE)) begin
                    if (needs_halted(eff_cmd)) begin
                        state_next = ST_WAIT_HALT;
                    end else if (eff_cmd == CMD_STEP) begin
                        state_next = ST_STEP_RUN;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WAIT_HALT: if (halted_i) state_next = ST_EXEC;
            ST_EXEC:      state_next = ST_DONE;
            ST_STEP_RUN:  if (retire_i) state_next = ST_STEP_STOP;
            ST_STEP_STOP: if (halted_i) state_next = ST_DONE;
            ST_DONE:      state_next = ST_WAIT_CLR;
            ST_WAIT_CLR:  if (dbg_cmd_i == 8'(CMD_NONE)) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_HALT_BIT]                 = halt_q;
        status_word[STAT_HALTED_BIT]               = halted_i;
        status_word[STAT_CAUSE_LSB +: 2]           = cause_q;
        status_word[STAT_BPIDX_LSB +: 4]           = bp_idx_q;
        status_word[STAT_ERR_BIT]                  = err_q;
        status_word[STAT_BPEN_LSB +: NUM_BP]       = bp_en;
    end

    always_comb begin
        dbg_done_o  = (state_q == ST_DONE);
        dbg_rdata_o = '0;
        rs_o        = '0;
        rd_o        = '0;
        rd_data_o   = '0;
        rd_we_o     = 1'b0;
        pc_o        = '0;
        flush_o     = 1'b0;
        case (state_q)
            ST_EXEC: begin
                case (cmd_q)
                    CMD_RD_REG: rs_o = dbg_addr_i[RF_AW-1:0];
                    CMD_WR_REG: begin
                        rd_we_o   = 1'b1;
                        rd_o      = dbg_addr_i[RF_AW-1:0];
                        rd_data_o = dbg_wdata_i;
                    end
                    CMD_WR_PC: begin
                        flush_o = 1'b1;
                        pc_o    = dbg_wdata_i;
                    end
                    default: ;
                endcase
            end
            ST_DONE: begin
                case (cmd_q)
                    CMD_RD_REG: dbg_rdata_o = rdata_q;
                    CMD_RD_PC:  dbg_rdata_o = pc_i;
                    CMD_STATUS: dbg_rdata_o = status_word;
                    default:    dbg_rdata_o = '0;
                endcase
            end
            default: ;
        endcase
    end

    assign halt_o = halt_q | tmp_q | step_hold_q;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_q       <= 8'(CMD_NONE);
            halt_q      <= RESET_HALTED;
            tmp_q       <= 1'b0;
            step_hold_q <= 1'b0;
            suppress_q  <= 1'b0;
            err_q       <= 1'b0;
            cause_q     <= RESET_HALTED ? CAUSE_DBG : CAUSE_NONE;
            bp_idx_q    <= '0;
            rdata_q     <= '0;
        end else begin
            if (retire_i) begin
                suppress_q <= 1'b0;
            end

            if (accept) begin
                cmd_q <= eff_cmd;
                case (eff_cmd)
                    CMD_HALT: begin
                        halt_q  <= 1'b1;
                        cause_q <= CAUSE_DBG;
                    end
                    CMD_RESUME: begin
                        halt_q     <= 1'b0;
                        cause_q    <= CAUSE_NONE;
                        suppress_q <= 1'b1;
                    end
                    CMD_RD_REG, CMD_WR_REG, CMD_WR_PC: tmp_q <= 1'b1;
                    CMD_STEP: begin
                        halt_q     <= 1'b0;
                        suppress_q <= 1'b1;
                    end
                    CMD_SET_BP, CMD_CLR_BP: if (!bp_sel_ok) err_q <= 1'b1;
                    CMD_RD_PC, CMD_STATUS: ;
                    default: err_q <= 1'b1;
                endcase
            end

            case (state_q)
                ST_EXEC: begin
                    tmp_q <= 1'b0;
                    if (cmd_q == CMD_RD_REG) begin
                        rdata_q <= rs_data_i;
                    end
                end
                ST_STEP_RUN: if (retire_i) step_hold_q <= 1'b1;
                ST_STEP_STOP: begin
                    if (halted_i) begin
                        halt_q      <= 1'b1;
                        step_hold_q <= 1'b0;
                        cause_q     <= CAUSE_STEP;
                    end
                end
                ST_DONE: if (cmd_q == CMD_STATUS) err_q <= 1'b0;
                default: ;
            endcase

            // Placed last so a breakpoint hit overrides a same-cycle resume.
            if (bp_hit) begin
                halt_q   <= 1'b1;
                cause_q  <= CAUSE_BP;
                bp_idx_q <= bp_idx;
            end
        end
    end

endmodule

// File: tb/tb_core_dbg_unit.sv
// Directed bench for core_dbg_unit: a vector table of debug commands plus
// hand-written breakpoint and single-step sequences against a simple core model.
module tb_core_dbg_unit;

    logic        clk;
    logic        rstn;
    logic [7:0]  dbg_cmd;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_done;
    logic        halt;
    logic        halted;
    logic        retire;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [31:0] rs_data;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        rd_we;
    logic [31:0] pc_new;
    logic        flush;
    logic [1:0]  hcnt;

    int n_tests = 0;
    int n_fail  = 0;

    core_dbg_unit dut (
        .clk         (clk),
        .rstn_i      (rstn),
        .dbg_cmd_i   (dbg_cmd),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_rdata_o (dbg_rdata),
        .dbg_done_o  (dbg_done),
        .halt_o      (halt),
        .halted_i    (halted),
        .retire_i    (retire),
        .pc_i        (pc),
        .rs_o        (rs),
        .rs_data_i   (rs_data),
        .rd_o        (rd),
        .rd_data_o   (rd_data),
        .rd_we_o     (rd_we),
        .pc_o        (pc_new),
        .flush_o     (flush)
    );

    always #5 clk = ~clk;

    // Core model: halted rises three cycles after halt_o, drops when released.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            halted <= 1'b0;
            hcnt   <= 2'd0;
        end else if (!halt) begin
            halted <= 1'b0;
            hcnt   <= 2'd0;
        end else if (!halted) begin
            if (hcnt == 2'd2) halted <= 1'b1;
            else              hcnt   <= hcnt + 2'd1;
        end
    end

    typedef struct {
        logic [31:0] cmd, addr, wdata;
        logic [31:0] rdata, halt, flush, pc_o, we, rd, rd_data, rs;
    } vec_t;

    typedef struct {
        logic [31:0] rdata, halt, flush, pc_o, we, rd, rd_data, rs;
        logic        got;
    } res_t;

    vec_t vecs [16];
    int   nv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic add(input logic [31:0] c, a, w, rdat, h, fl, pco, we, rdi, rdd, rsi);
        vecs[nv] = '{c, a, w, rdat, h, fl, pco, we, rdi, rdd, rsi};
        nv++;
    endtask

    task automatic do_cmd(input string tag, input logic [31:0] c, a, w, output res_t r);
        r.rdata = '0; r.halt = '0; r.flush = '0; r.pc_o = '0;
        r.we = '0; r.rd = '0; r.rd_data = '0; r.rs = '0; r.got = 1'b0;
        dbg_cmd   = c[7:0];
        dbg_addr  = a;
        dbg_wdata = w;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (flush) begin
                r.flush = r.flush + 1;
                r.pc_o  = pc_new;
            end
            if (rd_we) begin
                r.we      = r.we + 1;
                r.rd      = 32'(rd);
                r.rd_data = rd_data;
            end
            if (rs != 5'd0) r.rs = 32'(rs);
            if (dbg_done) begin
                r.got   = 1'b1;
                r.rdata = dbg_rdata;
                r.halt  = 32'(halt);
                break;
            end
        end
        chk({tag, " done_seen"}, 32'(r.got), 32'd1);
        @(posedge clk); #1;
        chk({tag, " done_width"}, 32'(dbg_done), 32'd0);
        chk({tag, " rdata_idle"}, dbg_rdata, 32'd0);
        dbg_cmd = 8'h00;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        logic got;

        clk = 1'b0; rstn = 1'b0; dbg_cmd = 8'h00; dbg_addr = '0; dbg_wdata = '0;
        retire = 1'b0; pc = 32'h40; rs_data = 32'hDEADBEEF;

        //    cmd     addr  wdata       rdata          halt fl pc_o   we rd rd_data     rs
        add(32'h0A, 0, 0,          32'h0,         0,   0, 0,     0, 0, 0,          0);
        add(32'h03, 5, 0,          32'hDEADBEEF,  0,   0, 0,     0, 0, 0,          5);
        add(32'h05, 0, 0,          32'h40,        0,   0, 0,     0, 0, 0,          0);
        add(32'h01, 0, 0,          32'h0,         1,   0, 0,     0, 0, 0,          0);
        add(32'h0A, 0, 0,          32'h7,         1,   0, 0,     0, 0, 0,          0);
        add(32'h06, 0, 32'h80,     32'h0,         1,   1, 32'h80, 0, 0, 0,         0);
        add(32'h04, 7, 32'h1234,   32'h0,         1,   0, 0,     1, 7, 32'h1234,   0);
        add(32'h08, 3, 32'h100,    32'h0,         1,   0, 0,     0, 0, 0,          0);
        add(32'h08, 2, 32'h100,    32'h0,         1,   0, 0,     0, 0, 0,          0);
        add(32'h08, 4, 32'h200,    32'h0,         1,   0, 0,     0, 0, 0,          0);
        add(32'h0A, 0, 0,          32'hC0107,     1,   0, 0,     0, 0, 0,          0);
        add(32'h0A, 0, 0,          32'hC0007,     1,   0, 0,     0, 0, 0,          0);
        add(32'h55, 0, 0,          32'h0,         1,   0, 0,     0, 0, 0,          0);
        add(32'h0A, 0, 0,          32'hC0107,     1,   0, 0,     0, 0, 0,          0);
        add(32'h0A, 0, 0,          32'hC0007,     1,   0, 0,     0, 0, 0,          0);

        #12;
        chk("reset halt_o",  32'(halt),     32'd0);
        chk("reset done",    32'(dbg_done), 32'd0);
        chk("reset rdata",   dbg_rdata,     32'd0);
        chk("reset flush",   32'(flush),    32'd0);
        chk("reset rd_we",   32'(rd_we),    32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < nv; i++) begin
            string t;
            t = $sformatf("v%0d cmd%02h", i, vecs[i].cmd[7:0]);
            do_cmd(t, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, r);
            chk({t, " rdata"},   r.rdata,   vecs[i].rdata);
            chk({t, " halt"},    r.halt,    vecs[i].halt);
            chk({t, " flush"},   r.flush,   vecs[i].flush);
            chk({t, " pc_o"},    r.pc_o,    vecs[i].pc_o);
            chk({t, " rd_we"},   r.we,      vecs[i].we);
            chk({t, " rd"},      r.rd,      vecs[i].rd);
            chk({t, " rd_data"}, r.rd_data, vecs[i].rd_data);
            chk({t, " rs"},      r.rs,      vecs[i].rs);
        end

        // Breakpoint: resume, retire once to lift suppression, then hit 0x100.
        do_cmd("resume", 32'h02, 0, 0, r);
        chk("resume halt", r.halt, 32'd0);
        retire = 1'b1; pc = 32'h44;
        @(posedge clk); #1;
        retire = 1'b0; pc = 32'h100;
        chk("bp pre", 32'(halt), 32'd0);
        @(posedge clk); #1;
        chk("bp hit", 32'(halt), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        do_cmd("bp status", 32'h0A, 0, 0, r);
        chk("bp status rdata", r.rdata, 32'hC002B);

        // Single step from the breakpoint PC: must not re-trigger before retire.
        dbg_cmd = 8'h07; dbg_addr = '0; dbg_wdata = '0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("step released%0d", k), 32'(halt), 32'd0);
        end
        retire = 1'b1; pc = 32'h104;
        @(posedge clk); #1;
        retire = 1'b0;
        chk("step rehalt", 32'(halt), 32'd1);
        got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (dbg_done) begin
                got = 1'b1;
                chk("step rdata", dbg_rdata, 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        chk("step done_seen", 32'(got), 32'd1);
        dbg_cmd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        do_cmd("step status", 32'h0A, 0, 0, r);
        chk("step status rdata", r.rdata, 32'hC002F);

        do_cmd("clr bp2", 32'h09, 2, 0, r);
        do_cmd("clr bp3", 32'h09, 3, 0, r);
        do_cmd("final status", 32'h0A, 0, 0, r);
        chk("final status rdata", r.rdata, 32'h2F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
